// File: rtl/ens_vote_argmax_if.sv
// rtl/ens_vote_argmax_if.sv - beat input and result output handshake bundle for ens_vote_argmax; out_tie present under ENS_VOTE_ARGMAX_TIE_FLAG_EN
interface ens_vote_argmax_if #(
  parameter int N_CLASSES = 10,
  parameter int SCORE_W   = 2,
  parameter int N_ENS     = 4,
  parameter int IDX_W     = 4
);
  localparam int ACC_W = SCORE_W + $clog2(N_ENS);

  logic                         in_valid;
  logic                         in_ready;
  logic [N_CLASSES*SCORE_W-1:0] in_scores;
  logic                         out_valid;
  logic                         out_ready;
  logic [IDX_W-1:0]             out_class;
  logic [ACC_W-1:0]             out_score;
`ifdef ENS_VOTE_ARGMAX_TIE_FLAG_EN
  logic                         out_tie;
`endif

  // Producer of beats and consumer of results
  modport master (
    output in_valid, in_scores, out_ready,
    input  in_ready, out_valid, out_class, out_score
`ifdef ENS_VOTE_ARGMAX_TIE_FLAG_EN
    , input out_tie
`endif
  );

  // The voting block itself
  modport slave (
    input  in_valid, in_scores, out_ready,
    output in_ready, out_valid, out_class, out_score
`ifdef ENS_VOTE_ARGMAX_TIE_FLAG_EN
    , output out_tie
`endif
  );
endinterface

// File: rtl/ens_vote_argmax.sv
// rtl/ens_vote_argmax.sv - per-class ensemble score summation followed by a one-class-per-cycle argmax; optional tie flag under ENS_VOTE_ARGMAX_TIE_FLAG_EN
module ens_vote_argmax #(
  parameter int N_CLASSES = 10,
  parameter int SCORE_W   = 2,
  parameter int N_ENS     = 4,
  parameter int IDX_W     = 4
) (
  input logic              clk,
  input logic              rst_n,
  ens_vote_argmax_if.slave bus
);
  localparam int ACC_W = SCORE_W + $clog2(N_ENS);
  localparam int CNT_W = (N_ENS > 1) ? $clog2(N_ENS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_ENS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CLASSES - 1);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [ACC_W-1:0] acc_q [N_CLASSES];
  logic [ACC_W-1:0] acc_d [N_CLASSES];
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic [ACC_W-1:0] best_score_q, best_score_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_class_q, out_class_d;
  logic [ACC_W-1:0] out_score_q, out_score_d;

  // Candidate values for the class currently under inspection
  logic [ACC_W-1:0] scan_val;
  logic             scan_take;
  logic [ACC_W-1:0] cand_score;
  logic [IDX_W-1:0] cand_idx;

`ifdef ENS_VOTE_ARGMAX_TIE_FLAG_EN
  logic tie_q, tie_d;
  logic out_tie_q, out_tie_d;
  logic cand_tie;
`endif

  // Accumulation only ever happens in ACCUM, so ready is purely a state decode
  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = out_valid_q;
  assign bus.out_class = out_class_q;
  assign bus.out_score = out_score_q;
`ifdef ENS_VOTE_ARGMAX_TIE_FLAG_EN
  assign bus.out_tie   = out_tie_q;
`endif

  // Compare step: index 0 always seeds the running best, later indices need a strict win
  always_comb begin
    scan_val   = acc_q[scan_idx_q];
    scan_take  = (scan_idx_q == '0) || (scan_val > best_score_q);
    cand_score = scan_take ? scan_val : best_score_q;
    cand_idx   = scan_take ? scan_idx_q : best_idx_q;
`ifdef ENS_VOTE_ARGMAX_TIE_FLAG_EN
    // A strictly better value (or the seed) wipes any earlier tie; equality records one
    if (scan_take) begin
      cand_tie = 1'b0;
    end else if (scan_val == best_score_q) begin
      cand_tie = 1'b1;
    end else begin
      cand_tie = tie_q;
    end
`endif
  end

  // Next-state logic for the ACCUM -> SCAN -> DONE frame sequence
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    acc_d        = acc_q;
    scan_idx_d   = scan_idx_q;
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    out_valid_d  = out_valid_q;
    out_class_d  = out_class_q;
    out_score_d  = out_score_q;
`ifdef ENS_VOTE_ARGMAX_TIE_FLAG_EN
    tie_d        = tie_q;
    out_tie_d    = out_tie_q;
`endif

    case (state_q)
      ST_ACCUM: begin
        if (bus.in_valid) begin
          // First beat loads so the previous frame's sums never leak in
          for (int c = 0; c < N_CLASSES; c++) begin
            if (beat_q == '0) begin
              acc_d[c] = ACC_W'(bus.in_scores[c*SCORE_W +: SCORE_W]);
            end else begin
              acc_d[c] = acc_q[c] + ACC_W'(bus.in_scores[c*SCORE_W +: SCORE_W]);
            end
          end
          if (beat_q == LAST_BEAT) begin
            beat_d       = '0;
            state_d      = ST_SCAN;
            scan_idx_d   = '0;
            best_score_d = '0;
            best_idx_d   = '0;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end

      ST_SCAN: begin
        best_score_d = cand_score;
        best_idx_d   = cand_idx;
`ifdef ENS_VOTE_ARGMAX_TIE_FLAG_EN
        tie_d        = cand_tie;
`endif
        if (scan_idx_q == LAST_IDX) begin
          // Publish the outcome including the last class's own comparison
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_class_d = cand_idx;
          out_score_d = cand_score;
`ifdef ENS_VOTE_ARGMAX_TIE_FLAG_EN
          out_tie_d   = cand_tie;
`endif
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end

      ST_DONE: begin
        // Result held until taken; ready reappears only on the next cycle
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACCUM;
        end
      end

      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ACCUM;
      beat_q       <= '0;
      for (int c = 0; c < N_CLASSES; c++) begin
        acc_q[c] <= '0;
      end
      scan_idx_q   <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
      out_valid_q  <= 1'b0;
      out_class_q  <= '0;
      out_score_q  <= '0;
`ifdef ENS_VOTE_ARGMAX_TIE_FLAG_EN
      tie_q        <= 1'b0;
      out_tie_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      acc_q        <= acc_d;
      scan_idx_q   <= scan_idx_d;
      best_score_q <= best_score_d;
      best_idx_q   <= best_idx_d;
      out_valid_q  <= out_valid_d;
      out_class_q  <= out_class_d;
      out_score_q  <= out_score_d;
`ifdef ENS_VOTE_ARGMAX_TIE_FLAG_EN
      tie_q        <= tie_d;
      out_tie_q    <= out_tie_d;
`endif
    end
  end
endmodule

// File: tb/tb_ens_vote_argmax.sv
// tb/tb_ens_vote_argmax.sv - randomized self-checking bench for ens_vote_argmax against a sum/argmax reference model
module tb_ens_vote_argmax;
  localparam int NC = 10;
  localparam int SW = 2;
  localparam int NE = 4;
  localparam int IW = 4;
  localparam int AW = 4;
  localparam int FW = NC * SW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [FW-1:0] frame [NE];
  int            gaps [NE];
  int            exp_class;
  int            exp_score;
  logic          exp_tie;

  ens_vote_argmax_if #(.N_CLASSES(NC), .SCORE_W(SW), .N_ENS(NE), .IDX_W(IW)) bus ();

  ens_vote_argmax #(.N_CLASSES(NC), .SCORE_W(SW), .N_ENS(NE), .IDX_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [FW-1:0] one_class(input int cls, input int val);
    logic [FW-1:0] v;
    v = '0;
    v[cls*SW +: SW] = SW'(val);
    return v;
  endfunction

  // Reference: per-class totals, largest total, first class holding it, tie if held twice
  task automatic model();
    int sums [NC];
    int best;
    int cnt;
    best = -1;
    for (int c = 0; c < NC; c++) begin
      sums[c] = 0;
      for (int b = 0; b < NE; b++) sums[c] += int'(frame[b][c*SW +: SW]);
      if (sums[c] > best) best = sums[c];
    end
    exp_score = best;
    exp_class = -1;
    cnt = 0;
    for (int c = 0; c < NC; c++) begin
      if (sums[c] == best) begin
        cnt++;
        if (exp_class < 0) exp_class = c;
      end
    end
    exp_tie = (cnt > 1);
  endtask

  task automatic zero_gaps();
    for (int b = 0; b < NE; b++) gaps[b] = 0;
  endtask

  task automatic send_beats(input int n);
    for (int b = 0; b < n; b++) begin
      repeat (gaps[b]) @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_scores = frame[b];
      @(posedge clk);
      @(negedge clk);
      accept_cyc   = cyc;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.out_class !== 4'd0) begin n_fail++; $display("FAIL reset_out_class got=%0d exp=0", bus.out_class); end
    n_checks++; if (bus.out_score !== 4'd0) begin n_fail++; $display("FAIL reset_out_score got=%0d exp=0", bus.out_score); end
`ifdef ENS_VOTE_ARGMAX_TIE_FLAG_EN
    n_checks++; if (bus.out_tie !== 1'b0) begin n_fail++; $display("FAIL reset_out_tie got=%b exp=0", bus.out_tie); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit seen;
    zero_gaps();
    for (int b = 0; b < NE; b++) frame[b] = one_class(3, 3);
    send_beats(NE);
    wait_valid(seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL basic_timeout got=no_valid exp=valid"); end
    n_checks++; if (cyc - accept_cyc !== NC) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", cyc - accept_cyc, NC); end
    n_checks++; if (bus.out_class !== 4'd3) begin n_fail++; $display("FAIL basic_class got=%0d exp=3", bus.out_class); end
    n_checks++; if (bus.out_score !== 4'd12) begin n_fail++; $display("FAIL basic_score got=%0d exp=12", bus.out_score); end
`ifdef ENS_VOTE_ARGMAX_TIE_FLAG_EN
    n_checks++; if (bus.out_tie !== 1'b0) begin n_fail++; $display("FAIL basic_tie got=%b exp=0", bus.out_tie); end
`endif
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_done got=%b exp=0", bus.in_ready); end
    take_result();
    n_checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin n_fail++; $display("FAIL basic_after_hs got=%b exp=01", {bus.out_valid, bus.in_ready}); end
    n_checks++; if (bus.out_class !== 4'd3) begin n_fail++; $display("FAIL basic_class_retained got=%0d exp=3", bus.out_class); end
  endtask

  task automatic test_ties();
    bit seen;
    zero_gaps();
    for (int b = 0; b < NE; b++) begin
      for (int c = 0; c < NC; c++) frame[b][c*SW +: SW] = SW'($urandom_range(0, 1));
      frame[b][2*SW +: SW] = 2'd2;
      frame[b][7*SW +: SW] = 2'd2;
    end
    send_beats(NE);
    wait_valid(seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL ties_timeout got=no_valid exp=valid"); end
    n_checks++; if (bus.out_class !== 4'd2) begin n_fail++; $display("FAIL ties_class got=%0d exp=2", bus.out_class); end
    n_checks++; if (bus.out_score !== 4'd8) begin n_fail++; $display("FAIL ties_score got=%0d exp=8", bus.out_score); end
`ifdef ENS_VOTE_ARGMAX_TIE_FLAG_EN
    n_checks++; if (bus.out_tie !== 1'b1) begin n_fail++; $display("FAIL ties_tie got=%b exp=1", bus.out_tie); end
`endif
    take_result();
  endtask

  task automatic test_reset_mid_frame();
    zero_gaps();
    for (int b = 0; b < NE; b++) frame[b] = FW'($urandom);
    send_beats(2);
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got=%b exp=1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.out_class !== 4'd0) begin n_fail++; $display("FAIL rstmid_out_class got=%0d exp=0", bus.out_class); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    begin
      bit seen;
      for (int b = 0; b < NE; b++) frame[b] = one_class(9, 1);
      send_beats(NE);
      wait_valid(seen);
      n_checks++; if (!seen) begin n_fail++; $display("FAIL rstmid_timeout got=no_valid exp=valid"); end
      n_checks++; if (bus.out_class !== 4'd9) begin n_fail++; $display("FAIL rstmid_class got=%0d exp=9", bus.out_class); end
      n_checks++; if (bus.out_score !== 4'd4) begin n_fail++; $display("FAIL rstmid_score got=%0d exp=4", bus.out_score); end
      take_result();
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    zero_gaps();
    for (int b = 0; b < NE; b++) frame[b] = FW'($urandom);
    model();
    send_beats(NE);
    wait_valid(seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL bp_timeout got=no_valid exp=valid"); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({bus.out_valid, bus.in_ready, bus.out_class, bus.out_score} !== {1'b1, 1'b0, IW'(exp_class), AW'(exp_score)}) begin
        n_fail++;
        $display("FAIL bp_hold cycle=%0d got v=%b r=%b cls=%0d sc=%0d exp v=1 r=0 cls=%0d sc=%0d",
                 i, bus.out_valid, bus.in_ready, bus.out_class, bus.out_score, exp_class, exp_score);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_bypass got=%b exp=0", bus.in_ready); end
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_after_hs got=%b exp=01", {bus.out_valid, bus.in_ready}); end
  endtask

  task automatic test_gapped();
    bit seen;
    bit bad_ready;
    int g_class;
    int g_score;
    gaps[0] = 2; gaps[1] = 0; gaps[2] = 1; gaps[3] = 3;
    for (int b = 0; b < NE; b++) frame[b] = FW'($urandom);
    model();
    send_beats(NE);
    bad_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.in_ready !== 1'b0) bad_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_scores = FW'($urandom);
      @(negedge clk);
    end
    repeat (3) begin
      if (bus.in_ready !== 1'b0) bad_ready = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_checks++; if (!seen) begin n_fail++; $display("FAIL gap_timeout got=no_valid exp=valid"); end
    n_checks++; if (bad_ready !== 1'b0) begin n_fail++; $display("FAIL gap_ready_busy got=1 exp=0"); end
    n_checks++; if (bus.out_class !== IW'(exp_class)) begin n_fail++; $display("FAIL gap_class got=%0d exp=%0d", bus.out_class, exp_class); end
    n_checks++; if (bus.out_score !== AW'(exp_score)) begin n_fail++; $display("FAIL gap_score got=%0d exp=%0d", bus.out_score, exp_score); end
    g_class = int'(bus.out_class);
    g_score = int'(bus.out_score);
    take_result();
    zero_gaps();
    send_beats(NE);
    wait_valid(seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL gapless_timeout got=no_valid exp=valid"); end
    n_checks++;
    if ({bus.out_class, bus.out_score} !== {IW'(exp_class), AW'(exp_score)}) begin
      n_fail++;
      $display("FAIL gapless_vs_gapped got cls=%0d sc=%0d exp cls=%0d sc=%0d (gapped gave %0d/%0d)",
               bus.out_class, bus.out_score, exp_class, exp_score, g_class, g_score);
    end
    take_result();
  endtask

  task automatic test_all_zero();
    bit seen;
    zero_gaps();
    for (int b = 0; b < NE; b++) frame[b] = '0;
    send_beats(NE);
    wait_valid(seen);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL zero_timeout got=no_valid exp=valid"); end
    n_checks++; if (bus.out_class !== 4'd0) begin n_fail++; $display("FAIL zero_class got=%0d exp=0", bus.out_class); end
    n_checks++; if (bus.out_score !== 4'd0) begin n_fail++; $display("FAIL zero_score got=%0d exp=0", bus.out_score); end
`ifdef ENS_VOTE_ARGMAX_TIE_FLAG_EN
    n_checks++; if (bus.out_tie !== 1'b1) begin n_fail++; $display("FAIL zero_tie got=%b exp=1", bus.out_tie); end
`endif
    take_result();
  endtask

  task automatic test_back_to_back();
    bit seen;
    int winners [2];
    winners[0] = 5;
    winners[1] = 1;
    zero_gaps();
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < NE; b++) begin
        for (int c = 0; c < NC; c++) frame[b][c*SW +: SW] = SW'($urandom_range(0, 1));
        frame[b][winners[f]*SW +: SW] = 2'd3;
      end
      send_beats(NE);
      wait_valid(seen);
      n_checks++; if (!seen) begin n_fail++; $display("FAIL b2b_timeout frame=%0d got=no_valid exp=valid", f); end
      n_checks++; if (bus.out_class !== IW'(winners[f])) begin n_fail++; $display("FAIL b2b_class frame=%0d got=%0d exp=%0d", f, bus.out_class, winners[f]); end
      n_checks++; if (bus.out_score !== 4'd12) begin n_fail++; $display("FAIL b2b_score frame=%0d got=%0d exp=12", f, bus.out_score); end
      take_result();
    end
  endtask

  task automatic test_random();
    bit seen;
    for (int f = 0; f < 12; f++) begin
      for (int b = 0; b < NE; b++) begin
        gaps[b] = $urandom_range(0, 2);
        for (int c = 0; c < NC; c++) frame[b][c*SW +: SW] = SW'($urandom_range(0, 3));
      end
      model();
      send_beats(NE);
      wait_valid(seen);
      n_checks++; if (!seen) begin n_fail++; $display("FAIL rand_timeout frame=%0d got=no_valid exp=valid", f); end
      n_checks++; if (cyc - accept_cyc !== NC) begin n_fail++; $display("FAIL rand_latency frame=%0d got=%0d exp=%0d", f, cyc - accept_cyc, NC); end
      n_checks++; if (bus.out_class !== IW'(exp_class)) begin n_fail++; $display("FAIL rand_class frame=%0d got=%0d exp=%0d", f, bus.out_class, exp_class); end
      n_checks++; if (bus.out_score !== AW'(exp_score)) begin n_fail++; $display("FAIL rand_score frame=%0d got=%0d exp=%0d", f, bus.out_score, exp_score); end
`ifdef ENS_VOTE_ARGMAX_TIE_FLAG_EN
      n_checks++; if (bus.out_tie !== exp_tie) begin n_fail++; $display("FAIL rand_tie frame=%0d got=%b exp=%b", f, bus.out_tie, exp_tie); end
`endif
      repeat ($urandom_range(0, 3)) @(negedge clk);
      take_result();
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_scores = '0;
    bus.out_ready = 1'b0;
    exp_tie       = 1'b0;
    test_reset();
    test_basic();
    test_ties();
    test_reset_mid_frame();
    test_backpressure();
    test_gapped();
    test_all_zero();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ens_vote_argmax.md
Name: ens_vote_argmax

Overview:
- Sits directly downstream of the final LUT-neuron layer of each MNIST ensemble member.
- Consumes the packed per-class output scores of N_ENS ensemble members as N_ENS consecutive beats of one frame.
- Sums the scores per class, then runs a sequential argmax over the sums.
- Emits the predicted digit class and its summed score through a valid/ready handshake.

Parameters:
- N_CLASSES, 10, number of classes; final layer output width is N_CLASSES*SCORE_W.
- SCORE_W, 2, unsigned score bits per class per ensemble member.
- N_ENS, 4, ensemble members (beats) per frame, minimum 1.
- IDX_W, 4, width of the class index; must satisfy 2^IDX_W >= N_CLASSES.
- ACC_W (localparam), SCORE_W+clog2(N_ENS), accumulator width; 4 at the defaults.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accept; a beat transfers on in_valid&&in_ready.
- in_scores  in  N_CLASSES*SCORE_W  class c occupies bits [c*SCORE_W +: SCORE_W], unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  result accept.
- out_class  out  IDX_W  argmax class index.
- out_score  out  ACC_W  summed score of out_class.

Behaviour:
- Reset (async assert, synchronous deassert to clk by the system):
  - state=ACCUM, beat counter=0, accumulators=0, scan index=0.
  - in_ready=1 (combinational from state), out_valid=0, out_class=0, out_score=0.
  - A frame in progress is discarded; reset mid-SCAN or mid-DONE drops the result.
- ACCUM:
  - in_ready=1.
  - On a transfer with beat counter 0: acc[c] <= zero-extended score[c], i.e. load, not add.
  - On any other transfer: acc[c] <= acc[c] + score[c]. No overflow is possible at the sized ACC_W.
  - Beat counter increments per transfer; idle cycles between beats are allowed.
  - On the N_ENS-th transfer: counter<=0, state<=SCAN, scan index<=0, best_score<=0, best_idx<=0.
- SCAN, one class per cycle:
  - in_ready=0.
  - At index i: if i==0 or acc[i] > best_score (strict), then best_score<=acc[i] and best_idx<=i.
  - Ties resolve to the lowest index.
  - After i==N_CLASSES-1 is evaluated: state<=DONE, out_class<=best/updated idx, out_score<=best/updated score, out_valid<=1.
- DONE:
  - in_ready=0.
  - out_valid, out_class and out_score are held stable until out_valid&&out_ready.
  - On that handshake: out_valid<=0, state<=ACCUM. in_ready is 1 in the following cycle, with no bypass in the handshake cycle.
- Latency: out_valid rises exactly N_CLASSES clock edges after the edge that accepts the last beat. Throughput is one frame per N_ENS+N_CLASSES+1 cycles minimum.
- out_class and out_score are don't-care-stable: they retain the last value while out_valid=0.
- Any in_valid or in_scores activity outside ACCUM is ignored.

Optional Feature:
- Macro: ENS_VOTE_ARGMAX_TIE_FLAG_EN.
- Defined:
  - Adds output port out_tie (1 bit). It resets to 0 and is updated with out_class.
  - out_tie=1 iff at least one other class has acc equal to the winning score.
  - Tracked during SCAN: the flag sets on equality with best_score and clears when a strictly greater value replaces best.
  - Held stable under the same rules as out_class.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic frame, defaults: 4 beats with class 3 score 3 and all others 0 -> out_class=3, out_score=12, out_valid 10 edges after the 4th accept.
- Ties: sums are class 2=8, class 7=8, others <=5 -> out_class=2, out_score=8; out_tie=1 when the macro is defined.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid/out_class/out_score stable and in_ready=0 throughout. Raise out_ready -> one handshake, then in_ready=1 next cycle.
- Gapped input: 4 beats separated by 0, 1 and 3 idle cycles, plus in_valid pulses sent during SCAN/DONE -> result identical to the gapless case, and extra pulses are not accepted.
- Reset mid-frame: 2 beats accepted, then rst_n pulsed low -> in_ready=1, out_valid=0, out_class=0 immediately. Next 4 beats (class 9 score 1 each) -> out_class=9, out_score=4.
- All-zero frame -> out_class=0, out_score=0; out_tie=1 if enabled. Two back-to-back frames with winners 5 then 1 -> both results produced in order.
